// File: rtl/ps2_mouse_init_sequencer_if.sv
// Signal bundle between the PS/2 mouse init sequencer, the PS2_Controller
// (command/receive side) and the cursor/button tracker.
// master = sequencer side, slave = controller/tracker side.
// Optional build macro MOUSE_WHEEL_EN adds the Z-movement byte pkt_byte4.
interface ps2_mouse_init_sequencer_if;
  logic [7:0] cmd_data;
  logic       cmd_send;
  logic       cmd_sent;
  logic       cmd_timeout;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] pkt_byte1;
  logic [7:0] pkt_byte2;
  logic [7:0] pkt_byte3;
`ifdef MOUSE_WHEEL_EN
  logic [7:0] pkt_byte4;
`endif
  logic       pkt_valid;
  logic       sync_err;
  logic       init_done;
  logic       init_fail;
  logic [1:0] retry_cnt;

`ifdef MOUSE_WHEEL_EN
  modport master (input  cmd_sent, cmd_timeout, rx_data, rx_valid,
                  output cmd_data, cmd_send, pkt_byte1, pkt_byte2, pkt_byte3, pkt_byte4,
                         pkt_valid, sync_err, init_done, init_fail, retry_cnt);
  modport slave  (output cmd_sent, cmd_timeout, rx_data, rx_valid,
                  input  cmd_data, cmd_send, pkt_byte1, pkt_byte2, pkt_byte3, pkt_byte4,
                         pkt_valid, sync_err, init_done, init_fail, retry_cnt);
`else
  modport master (input  cmd_sent, cmd_timeout, rx_data, rx_valid,
                  output cmd_data, cmd_send, pkt_byte1, pkt_byte2, pkt_byte3,
                         pkt_valid, sync_err, init_done, init_fail, retry_cnt);
  modport slave  (output cmd_sent, cmd_timeout, rx_data, rx_valid,
                  input  cmd_data, cmd_send, pkt_byte1, pkt_byte2, pkt_byte3,
                         pkt_valid, sync_err, init_done, init_fail, retry_cnt);
`endif
endinterface

// File: rtl/ps2_mouse_init_sequencer.sv
// PS/2 mouse bring-up sequencer: reset (FF), BAT/ID check, enable reporting
// (F4), then frames the stream into validated 3-byte packets with gap resync
// and hot-plug detection. Build macro MOUSE_WHEEL_EN adds the IntelliMouse
// knock, device-ID read and 4-byte wheel packets.
module ps2_mouse_init_sequencer #(
  parameter int RESP_TIMEOUT_CYC = 25000000,
  parameter int MAX_RETRIES      = 3,
  parameter int BYTE_GAP_CYC     = 100000
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  ps2_mouse_init_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    SEND_RST, WAIT_ACK1, WAIT_BAT, WAIT_ID, SEND_EN, WAIT_ACK2, RETRY, STREAM, FAIL
`ifdef MOUSE_WHEEL_EN
    , KNOCK_SEND, KNOCK_ACK, GET_ID
`endif
  } state_t;

  localparam logic [31:0] RESP_LAST = 32'(RESP_TIMEOUT_CYC - 1);
  localparam logic [31:0] GAP_LAST  = 32'(BYTE_GAP_CYC - 1);

  state_t      r_state, w_state_next, w_ack_fwd, w_ack_back;
  logic        r_resent, w_resent_next;
  logic [31:0] r_resp_tmr, r_gap_tmr;
  logic        r_cmd_send;
  logic [7:0]  r_cmd_data, w_cmd_byte;
  logic [1:0]  r_retry_cnt, r_idx;
  logic [7:0]  r_b1, r_b2, r_pkt1, r_pkt2, r_pkt3;
  logic        r_pkt_valid, r_sync_err, r_hp_armed;
  logic        w_in_send, w_in_wait, w_state_chg, w_done, w_abort;
  logic        w_resp_exp, w_hotplug, w_gap_exp, w_last_byte;
`ifdef MOUSE_WHEEL_EN
  logic [2:0]  r_knock, w_knock_next;
  logic        r_wheel;
  logic [7:0]  r_b3, r_pkt4;

  // Knock sequence: F3,C8 / F3,64 / F3,50 / F2 (index 6 is the ID request).
  function automatic logic [7:0] knock_byte(input logic [2:0] i);
    case (i)
      3'd1:    return 8'hC8;
      3'd3:    return 8'h64;
      3'd5:    return 8'h50;
      3'd6:    return 8'hF2;
      default: return 8'hF3;
    endcase
  endfunction
`endif

  // Classify the current state and pick the command byte it transmits.
  always_comb begin
    w_in_send  = (r_state == SEND_RST) || (r_state == SEND_EN);
    w_in_wait  = (r_state == WAIT_ACK1) || (r_state == WAIT_BAT) ||
                 (r_state == WAIT_ID)   || (r_state == WAIT_ACK2);
    w_cmd_byte = (r_state == SEND_EN) ? 8'hF4 : 8'hFF;
`ifdef MOUSE_WHEEL_EN
    if (r_state == KNOCK_SEND) begin
      w_in_send  = 1'b1;
      w_cmd_byte = knock_byte(r_knock);
    end
    if ((r_state == KNOCK_ACK) || (r_state == GET_ID)) w_in_wait = 1'b1;
    w_last_byte = r_wheel ? (r_idx == 2'd3) : (r_idx == 2'd2);
`else
    w_last_byte = (r_idx == 2'd2);
`endif
  end

  // A handshake only completes while the request is actually on the wire.
  assign w_done      = r_cmd_send & bus.cmd_sent;
  assign w_abort     = r_cmd_send & bus.cmd_timeout;
  assign w_resp_exp  = w_in_wait && (r_resp_tmr == RESP_LAST);
  assign w_hotplug   = (r_state == STREAM) && bus.rx_valid && r_hp_armed && (bus.rx_data == 8'h00);
  assign w_gap_exp   = (r_state == STREAM) && !bus.rx_valid && (r_idx != 2'd0) && (r_gap_tmr == GAP_LAST);
  assign w_state_chg = (w_state_next != r_state);

  // Next-state logic; an FE reply may resend the same command once per state.
  always_comb begin
    w_state_next  = r_state;
    w_resent_next = r_resent;
    w_ack_fwd     = WAIT_BAT;
    w_ack_back    = SEND_RST;
`ifdef MOUSE_WHEEL_EN
    w_knock_next  = r_knock;
    if (r_state == KNOCK_ACK) begin
      w_ack_fwd  = (r_knock == 3'd6) ? GET_ID : KNOCK_SEND;
      w_ack_back = KNOCK_SEND;
    end
`endif
    if (r_state == WAIT_ACK2) begin
      w_ack_fwd  = STREAM;
      w_ack_back = SEND_EN;
    end
    case (r_state)
      SEND_RST, SEND_EN: begin
        if (w_done)       w_state_next = (r_state == SEND_RST) ? WAIT_ACK1 : WAIT_ACK2;
        else if (w_abort) w_state_next = RETRY;
      end
`ifdef MOUSE_WHEEL_EN
      KNOCK_SEND: begin
        if (w_done)       w_state_next = KNOCK_ACK;
        else if (w_abort) w_state_next = RETRY;
      end
      GET_ID: begin
        if (bus.rx_valid)    w_state_next = SEND_EN;
        else if (w_resp_exp) w_state_next = RETRY;
      end
`endif
      WAIT_ACK1, WAIT_ACK2
`ifdef MOUSE_WHEEL_EN
      , KNOCK_ACK
`endif
      : begin
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'hFA) begin
            w_state_next  = w_ack_fwd;
            w_resent_next = 1'b0;
`ifdef MOUSE_WHEEL_EN
            if ((r_state == KNOCK_ACK) && (r_knock != 3'd6)) w_knock_next = r_knock + 3'd1;
`endif
          end else if ((bus.rx_data == 8'hFE) && !r_resent) begin
            w_state_next  = w_ack_back;
            w_resent_next = 1'b1;
          end else begin
            w_state_next = RETRY;
          end
        end else if (w_resp_exp) begin
          w_state_next = RETRY;
        end
      end
      WAIT_BAT: begin
        if (bus.rx_valid)    w_state_next = (bus.rx_data == 8'hAA) ? WAIT_ID : RETRY;
        else if (w_resp_exp) w_state_next = RETRY;
      end
      WAIT_ID: begin
        if (bus.rx_valid) begin
`ifdef MOUSE_WHEEL_EN
          w_state_next = (bus.rx_data == 8'h00) ? KNOCK_SEND : RETRY;
          w_knock_next = 3'd0;
`else
          w_state_next = (bus.rx_data == 8'h00) ? SEND_EN : RETRY;
`endif
        end else if (w_resp_exp) begin
          w_state_next = RETRY;
        end
      end
      RETRY: begin
        w_resent_next = 1'b0;
        w_state_next  = (({30'd0, r_retry_cnt} + 32'd1) == 32'(MAX_RETRIES)) ? FAIL : SEND_RST;
      end
      STREAM:  if (w_hotplug) w_state_next = SEND_EN;
      FAIL:    w_state_next = FAIL;
      default: w_state_next = SEND_RST;
    endcase
  end

  // State register and resend-once flag.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state  <= SEND_RST;
      r_resent <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_resent <= w_resent_next;
    end
  end

`ifdef MOUSE_WHEEL_EN
  // Knock progress and wheel mode latched from the device ID.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_knock <= 3'd0;
      r_wheel <= 1'b0;
    end else begin
      r_knock <= w_knock_next;
      if ((r_state == GET_ID) && bus.rx_valid) r_wheel <= (bus.rx_data == 8'h03);
    end
  end
`endif

  // Command request: rises the cycle after a SEND state is entered and
  // drops the cycle after the controller reports sent/timeout.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_cmd_send <= 1'b0;
      r_cmd_data <= 8'h00;
    end else begin
      r_cmd_send <= w_in_send && !w_state_chg;
      if (w_in_send) r_cmd_data <= w_cmd_byte;
    end
  end

  // Attempt counter: charged in RETRY, cleared on reaching STREAM.
  always_ff @(posedge CLOCK_50) begin
    if (reset)                                         r_retry_cnt <= 2'd0;
    else if (r_state == RETRY)                         r_retry_cnt <= r_retry_cnt + 2'd1;
    else if (w_state_chg && (w_state_next == STREAM)) r_retry_cnt <= 2'd0;
  end

  // Response timer: restarts on every state entry and every received byte.
  always_ff @(posedge CLOCK_50) begin
    if (reset || w_state_chg || bus.rx_valid) r_resp_tmr <= 32'd0;
    else if (w_in_wait)                       r_resp_tmr <= r_resp_tmr + 32'd1;
    else                                      r_resp_tmr <= 32'd0;
  end

  // Packet framer with bit3 alignment check, gap resync and hot-plug arming.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_idx       <= 2'd0;
      r_gap_tmr   <= 32'd0;
      r_hp_armed  <= 1'b0;
      r_b1        <= 8'h00;
      r_b2        <= 8'h00;
      r_pkt1      <= 8'h00;
      r_pkt2      <= 8'h00;
      r_pkt3      <= 8'h00;
      r_pkt_valid <= 1'b0;
      r_sync_err  <= 1'b0;
`ifdef MOUSE_WHEEL_EN
      r_b3        <= 8'h00;
      r_pkt4      <= 8'h00;
`endif
    end else begin
      r_pkt_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      if (r_state != STREAM) begin
        r_idx      <= 2'd0;
        r_gap_tmr  <= 32'd0;
        r_hp_armed <= 1'b0;
      end else if (bus.rx_valid) begin
        r_gap_tmr  <= 32'd0;
        r_hp_armed <= 1'b0;
        if (w_hotplug) begin
          r_idx <= 2'd0;
        end else if (r_idx == 2'd0) begin
          if (bus.rx_data[3]) begin
            r_b1       <= bus.rx_data;
            r_idx      <= 2'd1;
            r_hp_armed <= (bus.rx_data == 8'hAA);
          end else begin
            r_sync_err <= 1'b1;
          end
        end else if (w_last_byte) begin
          r_pkt1      <= r_b1;
          r_pkt2      <= r_b2;
          r_idx       <= 2'd0;
          r_pkt_valid <= 1'b1;
`ifdef MOUSE_WHEEL_EN
          if (r_wheel) begin
            r_pkt3 <= r_b3;
            r_pkt4 <= bus.rx_data;
          end else begin
            r_pkt3 <= bus.rx_data;
            r_pkt4 <= 8'h00;
          end
`else
          r_pkt3 <= bus.rx_data;
`endif
        end else begin
          if (r_idx == 2'd1) r_b2 <= bus.rx_data;
`ifdef MOUSE_WHEEL_EN
          else r_b3 <= bus.rx_data;
`endif
          r_idx <= r_idx + 2'd1;
        end
      end else if (w_gap_exp) begin
        r_idx      <= 2'd0;
        r_gap_tmr  <= 32'd0;
        r_hp_armed <= 1'b0;
        r_sync_err <= 1'b1;
      end else if (r_idx != 2'd0) begin
        r_gap_tmr <= r_gap_tmr + 32'd1;
      end
    end
  end

  assign bus.cmd_send  = r_cmd_send;
  assign bus.cmd_data  = r_cmd_data;
  assign bus.pkt_byte1 = r_pkt1;
  assign bus.pkt_byte2 = r_pkt2;
  assign bus.pkt_byte3 = r_pkt3;
`ifdef MOUSE_WHEEL_EN
  assign bus.pkt_byte4 = r_pkt4;
`endif
  assign bus.pkt_valid = r_pkt_valid;
  assign bus.sync_err  = r_sync_err;
  assign bus.init_done = (r_state == STREAM);
  assign bus.init_fail = (r_state == FAIL);
  assign bus.retry_cnt = r_retry_cnt;

endmodule

// File: doc/ps2_mouse_init_sequencer.md
Name: ps2_mouse_init_sequencer

Overview:
- Sequences the PS/2 controller after reset: resets the mouse, checks the BAT/ID responses, enables data reporting, then frames the byte stream into validated 3-byte packets.
- Sits between PS2_Controller (command and receive side) and the cursor/button tracking logic.
- Handles retries, response timeouts, packet resync and mouse hot-plug.

Parameters:
- RESP_TIMEOUT_CYC, 25000000: max cycles waiting for any response byte (500 ms at 50 MHz; covers BAT).
- MAX_RETRIES, 3: full init attempts before declaring failure.
- BYTE_GAP_CYC, 100000: intra-packet idle cycles (2 ms) after which the framer resyncs.

Ports:
- CLOCK_50, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- cmd_data, out, 8: command byte to PS2_Controller.
- cmd_send, out, 1: command request; held high until cmd_sent or cmd_timeout.
- cmd_sent, in, 1: 1-cycle pulse, command transmitted.
- cmd_timeout, in, 1: 1-cycle pulse, controller transmit timed out.
- rx_data, in, 8: received byte.
- rx_valid, in, 1: 1-cycle pulse, rx_data valid.
- pkt_byte1, out, 8: buttons/sign/overflow byte (bit3 always 1).
- pkt_byte2, out, 8: X movement.
- pkt_byte3, out, 8: Y movement.
- pkt_valid, out, 1: 1-cycle pulse, pkt_byte* updated.
- sync_err, out, 1: 1-cycle pulse, byte discarded by the framer.
- init_done, out, 1: high while in STREAM.
- init_fail, out, 1: high in FAIL (sticky until reset).
- retry_cnt, out, 2: init attempts consumed.

Behaviour:
- Reset values:
  - cmd_send=0, cmd_data=8'h00.
  - pkt_byte1/2/3=8'h00, pkt_valid=0, sync_err=0.
  - init_done=0, init_fail=0, retry_cnt=0.
  - byte index=0, timers=0.
  - State SEND_RST.
- States and transitions:
  - SEND_RST: cmd_data=FF, cmd_send=1. cmd_sent -> WAIT_ACK1; cmd_timeout -> RETRY.
  - WAIT_ACK1: FA -> WAIT_BAT; FE -> SEND_RST (no retry charged, max 1 resend per state, then RETRY); other byte or timer expiry -> RETRY.
  - WAIT_BAT: AA -> WAIT_ID; FC or other byte or timer expiry -> RETRY.
  - WAIT_ID: 00 -> SEND_EN; else -> RETRY.
  - SEND_EN: cmd_data=F4, handshake as in SEND_RST -> WAIT_ACK2.
  - WAIT_ACK2: FA -> STREAM; FE -> resend F4 once; else -> RETRY.
  - RETRY (1 cycle): retry_cnt+1. If the new count equals MAX_RETRIES -> FAIL, else -> SEND_RST.
  - STREAM: init_done=1. retry_cnt cleared on entry.
  - FAIL: terminal; only reset exits.
- Response timer:
  - Cleared on every state entry and every rx_valid.
  - Counts only in WAIT_* states.
  - Expiry when it reaches RESP_TIMEOUT_CYC-1.
- cmd_send:
  - Asserted the cycle after entering a SEND state.
  - Deasserted the cycle after cmd_sent/cmd_timeout.
  - Never asserted outside SEND states.
- rx_valid during SEND states is ignored.
- Framer (STREAM only):
  - idx0: byte accepted only if bit3=1, else sync_err pulse and byte dropped.
  - Bytes are stored in idx 0,1,2 order.
  - On the 3rd byte, pkt_byte1..3 update together and pkt_valid pulses 1 cycle after the rx_valid of byte 3. Outputs hold between packets.
- Gap timer:
  - Runs while idx!=0; cleared on rx_valid.
  - Expiry -> idx=0, partial packet dropped, sync_err pulse.
- Hot-plug: AA at idx0 followed by 00 as the next byte -> leave STREAM, init_done=0, go to SEND_EN with retry_cnt=0. AA alone is framed normally (bit3=1).
- Reset asserted mid-handshake: everything returns to reset values next cycle; cmd_send drops immediately.

Optional Feature:
- Macro MOUSE_WHEEL_EN.
- When defined, after WAIT_ID the sequencer issues the IntelliMouse knock, each byte with the normal ack handling, then reads the device ID:
  - F3,C8 / F3,64 / F3,50 (each byte ack FA).
  - F2, ack FA, then an ID byte.
- ID 03 sets wheel mode: 4-byte packets, extra port pkt_byte4 out 8 (Z movement).
- Any other ID keeps 3-byte mode with pkt_byte4=00.
- Then proceeds to SEND_EN.
- Without the macro the knock states, the ID logic and the pkt_byte4 port do not exist.

Test Plan:
- Normal init: after reset, expect cmd FF. Send cmd_sent, then FA, AA, 00. Expect cmd F4; after cmd_sent and FA, init_done=1 and retry_cnt=0.
- Packets: in STREAM, feed 09,05,FB -> pkt_valid one pulse, pkt_byte1/2/3=09/05/FB. Feed 01 first -> sync_err, no pkt_valid.
- Gap resync: feed 08,10, then 100000 idle cycles, then 08,01,02 -> sync_err once, then packet 08/01/02.
- Retries: respond FC to every BAT -> RETRY three times, init_fail=1, retry_cnt=3, cmd_send stays 0.
- Resend/timeout: reply FE to FF -> FF resent, no retry charged. Then withhold all responses for RESP_TIMEOUT_CYC -> retry_cnt=1, FF reissued.
- Hot-plug and reset: in STREAM feed AA,00 -> init_done=0, cmd F4 issued. Assert reset during a SEND state -> cmd_send=0 next cycle, state SEND_RST.
